// File: rtl/rv32imf_obi_arb_pkg.sv
// Shared types for the instruction/data OBI memory arbiter.
package rv32imf_obi_arb_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rv32imf_fifo.sv
// Small synchronous FIFO with optional fall-through. DEPTH must be a power of 2
// so the pointers wrap naturally.
module rv32imf_fifo #(
  parameter int DATA_WIDTH   = 1,
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [PW:0]           cnt_q;
  logic                  full_s, ft_s, push_mem_s, pop_mem_s;

  assign empty_o    = (cnt_q == {(PW+1){1'b0}});
  assign full_s     = (cnt_q == (PW+1)'(DEPTH));
  // A fall-through push that is popped in the same cycle never touches storage.
  assign ft_s       = FALL_THROUGH && empty_o && push_i;
  assign pop_mem_s  = pop_i && !empty_o;
  assign push_mem_s = push_i && (!full_s || pop_mem_s) && !(ft_s && pop_i);
  assign data_o     = ft_s ? data_i : mem_q[rptr_q];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wptr_q <= {PW{1'b0}};
      rptr_q <= {PW{1'b0}};
      cnt_q  <= {(PW+1){1'b0}};
    end else begin
      if (push_mem_s) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_mem_s) begin
        rptr_q <= rptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      cnt_q <= cnt_q + (PW+1)'(push_mem_s) - (PW+1)'(pop_mem_s);
    end
  end

endmodule

// File: rtl/rv32imf_obi_mem_arbiter_chk.sv
// Protocol checker for the arbiter's memory side: a response must never arrive
// while nothing is outstanding. en_i allows deliberately illegal traffic.
module rv32imf_obi_mem_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic en_i,
  input logic mem_req_i,
  input logic mem_gnt_i,
  input logic mem_rvalid_i
);

  logic [7:0] outst_q;
  logic       acc_s, rsp_s;

  assign acc_s = mem_req_i && mem_gnt_i;
  assign rsp_s = mem_rvalid_i && (outst_q != 8'd0);

  // Independent count of accepted but unanswered transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= 8'd0;
    end else begin
      outst_q <= outst_q + {7'd0, acc_s} - {7'd0, rsp_s};
    end
  end

  a_no_orphan_rvalid : assert property (
    @(posedge clk) disable iff (!rst_n || !en_i)
    mem_rvalid_i |-> (outst_q != 8'd0)
  );

endmodule

// File: rtl/rv32imf_obi_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and data load/store.
// Define RV32IMF_OBI_ARB_ROUND_ROBIN_EN for round-robin instead of data priority.
module rv32imf_obi_mem_arbiter
  import rv32imf_obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e        state_q, state_d;
  arb_src_e          sel_s, head_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_s, sel_req_s, accept_s, pop_s, fifo_empty_s;
  logic [0:0]        push_data_s, head_bit_s;
`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
  arb_src_e          rr_q, rr_d;
`endif

  // Owner selection: a held master keeps the port until its grant arrives
  always_comb begin
    sel_s = SRC_INSTR;
    case (state_q)
      ARB_HOLD_I: sel_s = SRC_INSTR;
      ARB_HOLD_D: sel_s = SRC_DATA;
      ARB_IDLE: begin
`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
        if (instr_req_i && data_req_i) begin
          sel_s = rr_q;
        end else if (data_req_i) begin
          sel_s = SRC_DATA;
        end else begin
          sel_s = SRC_INSTR;
        end
`else
        if (data_req_i) begin
          sel_s = SRC_DATA;
        end else begin
          sel_s = SRC_INSTR;
        end
`endif
      end
      default: sel_s = SRC_INSTR;
    endcase
  end

  assign full_s      = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign sel_req_s   = (sel_s == SRC_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o   = sel_req_s && !full_s;
  assign accept_s    = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = accept_s && (sel_s == SRC_INSTR);
  assign data_gnt_o  = accept_s && (sel_s == SRC_DATA);
  assign busy_o      = (count_q != {CNT_W{1'b0}}) || mem_req_o;

  // Address-phase mux; idle port drives all zeros
  always_comb begin
    mem_addr_o  = {ADDR_WIDTH{1'b0}};
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = 32'h0000_0000;
    if (mem_req_o && (sel_s == SRC_DATA)) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else if (mem_req_o) begin
      mem_addr_o  = instr_addr_i;
      mem_be_o    = 4'b1111;
    end else begin
      mem_addr_o  = {ADDR_WIDTH{1'b0}};
    end
  end

  // Responses with nothing outstanding are dropped rather than popped
  assign pop_s       = mem_rvalid_i && !fifo_empty_s;
  assign push_data_s = sel_s;
  assign head_s      = arb_src_e'(head_bit_s);

  assign instr_rvalid_o = pop_s && (head_s == SRC_INSTR);
  assign data_rvalid_o  = pop_s && (head_s == SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0000_0000;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0000_0000;
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;

  rv32imf_fifo #(
    .DATA_WIDTH   (1),
    .DEPTH        (MAX_OUTSTANDING),
    .FALL_THROUGH (1'b0)
  ) u_route_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .data_o  (head_bit_s),
    .empty_o (fifo_empty_s)
  );

  // Next-state: lock, outstanding count and round-robin pointer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = (sel_s == SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        if (accept_s) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
    if (accept_s) begin
      rr_d = (sel_s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else begin
      rr_d = rr_q;
    end
`endif
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      count_q <= {CNT_W{1'b0}};
`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
      rr_q    <= SRC_INSTR;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef RV32IMF_OBI_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule
